// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcode decode, forwarding-select encoding and hazard FSM states for the
// five-stage pipeline controller.
package pipeline_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_OUT   = 4'b0100;
  localparam logic [3:0] OP_LOAD  = 4'b0111;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    StRun,
    StOutWait
  } hz_state_t;

  function automatic logic is_writer(input logic [3:0] op);
    return op inside {4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001};
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// E/M/W instruction tracker: follows opcode and register fields down the pipe,
// honouring the same stall/flush controls as the real pipeline registers.
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stallE,
  input  logic                  flushE,
  input  logic                  flushM,
  input  logic [3:0]            opD,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  output logic [3:0]            opE,
  output logic [REG_ADDR_W-1:0] rdE,
  output logic [REG_ADDR_W-1:0] rs1E,
  output logic [REG_ADDR_W-1:0] rs2E,
  output logic [3:0]            opM,
  output logic [REG_ADDR_W-1:0] rdM,
  output logic [3:0]            opW,
  output logic [REG_ADDR_W-1:0] rdW
);

  logic [3:0]            e_op_q, m_op_q, w_op_q;
  logic [REG_ADDR_W-1:0] e_rd_q, e_rs1_q, e_rs2_q, m_rd_q, w_rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_op_q  <= OP_NOP;
      e_rd_q  <= '0;
      e_rs1_q <= '0;
      e_rs2_q <= '0;
      m_op_q  <= OP_NOP;
      m_rd_q  <= '0;
      w_op_q  <= OP_NOP;
      w_rd_q  <= '0;
    end else begin
      // A held E stage must not also advance into M, so M takes a bubble.
      if (stallE || flushM) begin
        m_op_q <= OP_NOP;
        m_rd_q <= '0;
      end else begin
        m_op_q <= e_op_q;
        m_rd_q <= e_rd_q;
      end

      if (!stallE) begin
        if (flushE) begin
          e_op_q  <= OP_NOP;
          e_rd_q  <= '0;
          e_rs1_q <= '0;
          e_rs2_q <= '0;
        end else begin
          e_op_q  <= opD;
          e_rd_q  <= rdD;
          e_rs1_q <= rs1D;
          e_rs2_q <= rs2D;
        end
      end

      w_op_q <= m_op_q;
      w_rd_q <= m_rd_q;
    end
  end

  assign opE  = e_op_q;
  assign rdE  = e_rd_q;
  assign rs1E = e_rs1_q;
  assign rs2E = e_rs2_q;
  assign opM  = m_op_q;
  assign rdM  = m_rd_q;
  assign opW  = w_op_q;
  assign rdW  = w_rd_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, E-stage
// forwarding selects and the OUT handshake hold with timeout.
module hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned OUT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            opcodeD,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic                  useRs1D,
  input  logic                  useRs2D,
  input  logic                  branchTakenE,
  input  logic                  outAck,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  flushM,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
  output logic                  outValid,
  output logic                  outError
);

  localparam int unsigned CntW = $clog2(OUT_TIMEOUT + 1);

  logic [3:0]            opE, opM, opW;
  logic [REG_ADDR_W-1:0] rdE, rs1E, rs2E, rdM, rdW;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .stallE (stallE),
    .flushE (flushE),
    .flushM (flushM),
    .opD    (opcodeD),
    .rdD    (rdD),
    .rs1D   (rs1D),
    .rs2D   (rs2D),
    .opE    (opE),
    .rdE    (rdE),
    .rs1E   (rs1E),
    .rs2E   (rs2E),
    .opM    (opM),
    .rdM    (rdM),
    .opW    (opW),
    .rdW    (rdW)
  );

  hz_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            load_use;
  logic            timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign load_use = (opE == OP_LOAD) &&
                    ((useRs1D && (rdE == rs1D)) || (useRs2D && (rdE == rs2D)));
  // Counter starts at 0 on the first OUT_WAIT cycle, so the last permitted cycle is TIMEOUT-1.
  assign timeout  = (cnt_q == CntW'(OUT_TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    stallF   = 1'b0;
    stallD   = 1'b0;
    stallE   = 1'b0;
    flushD   = 1'b0;
    flushE   = 1'b0;
    flushM   = 1'b0;
    outValid = 1'b0;
    unique case (state_q)
      StRun: begin
        if (opE == OP_OUT) begin
          stallF  = 1'b1;
          stallD  = 1'b1;
          stallE  = 1'b1;
          flushM  = 1'b1;
          state_d = StOutWait;
          cnt_d   = '0;
        end else if (branchTakenE) begin
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (load_use) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
      StOutWait: begin
        outValid = 1'b1;
        if (outAck || timeout) begin
          state_d = StRun;
          if (!outAck) err_d = 1'b1;
        end else begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          flushM = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  function automatic fwd_sel_t fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                       input logic [3:0] op_m, input logic [REG_ADDR_W-1:0] rd_m,
                                       input logic [3:0] op_w, input logic [REG_ADDR_W-1:0] rd_w);
    // A load in M has no data yet; it is picked up from W one cycle later.
    if (is_writer(op_m) && (op_m != OP_LOAD) && (rd_m == rs)) return FWD_M;
    if (is_writer(op_w) && (rd_w == rs)) return FWD_W;
    return FWD_RF;
  endfunction

  assign forwardAE = fwd_sel(rs1E, opM, rdM, opW, rdW);
  assign forwardBE = fwd_sel(rs2E, opM, rdM, opW, rdW);
  assign outError  = err_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with a short OUT timeout.
module tb_hazard_controller;

  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] OUT = 4'b0100;
  localparam logic [3:0] ADD = 4'b0101;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] LDW = 4'b0111;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcodeD, rdD, rs1D, rs2D;
  logic       useRs1D, useRs2D, branchTakenE, outAck;
  logic       stallF, stallD, stallE, flushD, flushE, flushM, outValid, outError;
  logic [1:0] forwardAE, forwardBE;
  logic [7:0] ctl;

  int checks   = 0;
  int failures = 0;

  hazard_controller #(
    .REG_ADDR_W  (4),
    .OUT_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcodeD      (opcodeD),
    .rdD          (rdD),
    .rs1D         (rs1D),
    .rs2D         (rs2D),
    .useRs1D      (useRs1D),
    .useRs2D      (useRs2D),
    .branchTakenE (branchTakenE),
    .outAck       (outAck),
    .stallF       (stallF),
    .stallD       (stallD),
    .stallE       (stallE),
    .flushD       (flushD),
    .flushE       (flushE),
    .flushM       (flushM),
    .forwardAE    (forwardAE),
    .forwardBE    (forwardBE),
    .outValid     (outValid),
    .outError     (outError)
  );

  always #5 clk = ~clk;

  // {stallF, stallD, stallE, flushD, flushE, flushM, outValid, outError}
  assign ctl = {stallF, stallD, stallE, flushD, flushE, flushM, outValid, outError};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] r1,
                       input logic [3:0] r2, input logic u1, input logic u2);
    opcodeD = op;
    rdD     = rd;
    rs1D    = r1;
    rs2D    = r2;
    useRs1D = u1;
    useRs2D = u2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    branchTakenE = 1'b0;
    outAck       = 1'b0;
    drive(NOP, 0, 0, 0, 0, 0);
    #2;
    chk("reset_ctl", ctl, 8'b0000_0000);
    chk("reset_fwdA", {6'd0, forwardAE}, 8'd0);
    chk("reset_fwdB", {6'd0, forwardBE}, 8'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Load-use: one bubble, then forward from W
    drive(LDW, 3, 0, 0, 0, 0);
    adv();
    drive(ADD, 4, 3, 0, 1, 0);
    #1 chk("loaduse_stall", ctl, 8'b1100_1000);
    adv();
    #1 chk("loaduse_bubble", ctl, 8'b0000_0000);
    adv();
    drive(NOP, 0, 0, 0, 0, 0);
    #1 chk("loaduse_fwdA_W", {6'd0, forwardAE}, 8'd1);
    chk("loaduse_fwdB_RF", {6'd0, forwardBE}, 8'd0);

    // Forwarding from M, from W, and M priority
    drive(ADD, 2, 0, 0, 0, 0);
    adv();
    drive(SUB, 5, 1, 2, 1, 1);
    adv();
    #1 chk("fwd_M_B", {6'd0, forwardBE}, 8'd2);
    chk("fwd_M_A_none", {6'd0, forwardAE}, 8'd0);
    drive(ADD, 2, 0, 0, 0, 0);
    adv();
    drive(NOP, 0, 0, 0, 0, 0);
    adv();
    drive(SUB, 5, 1, 2, 1, 1);
    adv();
    #1 chk("fwd_W_B", {6'd0, forwardBE}, 8'd1);
    drive(ADD, 2, 0, 0, 0, 0);
    adv();
    adv();
    drive(SUB, 5, 2, 2, 1, 1);
    adv();
    #1 chk("fwd_MW_A", {6'd0, forwardAE}, 8'd2);
    chk("fwd_MW_B", {6'd0, forwardBE}, 8'd2);
    // Load in M must not forward; the older ADD in W does
    drive(ADD, 2, 0, 0, 0, 0);
    adv();
    drive(LDW, 2, 0, 0, 0, 0);
    adv();
    drive(SUB, 5, 0, 2, 0, 0);
    #1 chk("no_loaduse_unused_rs", ctl, 8'b0000_0000);
    adv();
    #1 chk("fwd_load_in_M", {6'd0, forwardBE}, 8'd1);

    // Branch beats load-use
    drive(LDW, 3, 0, 0, 0, 0);
    adv();
    drive(ADD, 4, 3, 0, 1, 0);
    branchTakenE = 1'b1;
    #1 chk("branch_over_loaduse", ctl, 8'b0001_1000);
    adv();
    branchTakenE = 1'b0;
    drive(NOP, 0, 0, 0, 0, 0);
    #1 chk("branch_after", ctl, 8'b0000_0000);

    // OUT acked on the third OUT_WAIT cycle
    drive(OUT, 0, 1, 0, 1, 0);
    adv();
    drive(ADD, 6, 0, 0, 0, 0);
    #1 chk("out_detect", ctl, 8'b1110_0100);
    adv();
    #1 chk("out_wait1", ctl, 8'b1110_0110);
    adv();
    #1 chk("out_wait2", ctl, 8'b1110_0110);
    adv();
    outAck = 1'b1;
    #1 chk("out_ack", ctl, 8'b0000_0010);
    adv();
    outAck = 1'b0;
    #1 chk("out_resume", ctl, 8'b0000_0000);
    drive(SUB, 7, 6, 0, 1, 0);
    adv();
    drive(NOP, 0, 0, 0, 0, 0);
    #1 chk("out_resume_fwd", {6'd0, forwardAE}, 8'd2);

    // Timeout without ack
    drive(OUT, 0, 0, 0, 0, 0);
    adv();
    drive(NOP, 0, 0, 0, 0, 0);
    #1 chk("to_detect", ctl, 8'b1110_0100);
    adv();
    #1 chk("to_wait1", ctl, 8'b1110_0110);
    adv();
    adv();
    #1 chk("to_wait3", ctl, 8'b1110_0110);
    adv();
    #1 chk("to_release", ctl, 8'b0000_0010);
    adv();
    #1 chk("to_error", ctl, 8'b0000_0001);
    // Sticky error across a clean OUT
    drive(OUT, 0, 0, 0, 0, 0);
    adv();
    drive(NOP, 0, 0, 0, 0, 0);
    #1 chk("sticky_detect", ctl, 8'b1110_0101);
    adv();
    outAck = 1'b1;
    #1 chk("sticky_ack", ctl, 8'b0000_0011);
    adv();
    outAck = 1'b0;
    #1 chk("sticky_after", ctl, 8'b0000_0001);

    // Reset in OUT_WAIT
    drive(OUT, 0, 0, 0, 0, 0);
    adv();
    drive(NOP, 0, 0, 0, 0, 0);
    adv();
    #1 chk("pre_reset_wait", ctl, 8'b1110_0111);
    reset = 1'b1;
    #1 chk("reset_mid_wait", ctl, 8'b0000_0000);
    adv();
    reset = 1'b0;

    // Ack coinciding with the timeout cycle: no error
    drive(OUT, 0, 0, 0, 0, 0);
    adv();
    drive(NOP, 0, 0, 0, 0, 0);
    adv();
    adv();
    adv();
    adv();
    outAck = 1'b1;
    #1 chk("ack_at_timeout", ctl, 8'b0000_0010);
    adv();
    outAck = 1'b0;
    #1 chk("ack_at_timeout_noerr", ctl, 8'b0000_0000);

    // Clean decode after reset
    drive(ADD, 7, 0, 0, 0, 0);
    adv();
    drive(SUB, 1, 7, 0, 1, 0);
    adv();
    #1 chk("post_reset_fwd", {6'd0, forwardAE}, 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 4-bit-opcode five-stage processor. It tracks destination registers through E/M/W, generates load-use stalls, branch flushes and E-stage operand forwarding selects, and holds the pipeline on an OUT instruction until the external output port acknowledges or a timeout expires. It sits beside the decode-stage control unit and drives the stall, flush and mux-select inputs of the pipeline registers and datapath.

## Interface
- REG_ADDR_W, 4, register address width
- OUT_TIMEOUT, 255, maximum OUT_WAIT cycles before forced release (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcodeD  in  4  opcode in decode stage (IF/ID flushed → 4'b0000 = NOP)
- rdD, rs1D, rs2D  in  REG_ADDR_W  decode-stage register fields
- useRs1D, useRs2D  in  1  D instruction actually reads rs1/rs2
- branchTakenE  in  1  branch resolved taken in execute this cycle
- outAck  in  1  output port accepts data
- stallF, stallD  out  1  hold PC / IF/ID
- stallE  out  1  hold ID/EX
- flushD, flushE, flushM  out  1  clear IF/ID, ID/EX, EX/MEM to NOP next edge
- forwardAE, forwardBE  out  2  00 register file, 01 from W, 10 from M
- outValid  out  1  E-stage operand valid for output port
- outError  out  1  sticky: an OUT timed out

## Operation
- Decode (from package): writers = 0010,0011,0101,0110,0111,1000,1001; LOAD = 0111; OUT = 0100; everything else no writeback.
- Tracker: E{op,rd,rs1,rs2}, M{op,rd}, W{op,rd}. Per edge: normal → D→E→M→W; flushE → E gets NOP; stallE → E holds, M gets NOP; M→W always.
- FSM states RUN, OUT_WAIT.
- RUN, priority high→low:
  1. opE==OUT: stallF=stallD=stallE=flushM=1; next OUT_WAIT, counter=0.
  2. branchTakenE: flushD=flushE=1, no stall.
  3. Load-use: opE==LOAD and rdE matches (useRs1D & rs1D) or (useRs2D & rs2D): stallF=stallD=flushE=1 for exactly one cycle.
- OUT_WAIT: outValid=1. outAck=0 → same stall/flushM as RUN case 1, counter+1. outAck=1 → no stall, OUT advances to M, next RUN. Counter reaching OUT_TIMEOUT without ack → release as if acked, set outError.
- Forwarding (combinational on E sources): M writer, not LOAD, rdM==rsE → 10; else W writer, rdW==rsE → 01; else 00. M has priority over W.
- outError clears only on reset.

## Timing
- Reset: state RUN, tracker all NOP, counter 0, outError 0; all outputs 0 immediately (async).
- Stall/flush/forward outputs combinational from state + tracker + D inputs; take effect at next edge.
- OUT: 1 RUN detect cycle + N OUT_WAIT cycles; outValid first high the cycle after OUT enters E; ack cycle is the last outValid cycle and the OUT advances on that edge.
- Timeout: release on the OUT_TIMEOUT-th OUT_WAIT cycle; outError high from following cycle.
- Load-use costs exactly one bubble; load then forwards from W (01).
- Simultaneous outAck and timeout: treated as ack, outError unchanged.
- Reset mid-OUT_WAIT: outValid drops at once; no ack expected afterward.

## Structure
- Package pipeline_ctrl_pkg: opcode localparams (OP_NOP, OP_STORE, OP_OUT, OP_LOAD), is_writer function, fwd_sel_t enum (FWD_RF, FWD_W, FWD_M), hz_state_t enum.
- One sub-module: hazard_scoreboard (E/M/W tracker with stall/flush inputs, exposes stage fields). FSM, counter, priority and forwarding in top.

## Test plan
- Load-use: LOAD r3 then ADD (0101) reading r3 (useRs1D=1) → one cycle stallF=stallD=flushE=1, then forwardAE=01 next E cycle.
- Forwarding: ADD r2 then SUB (0110) reading r2 as rs2 → forwardBE=10; with one NOP between → 01; both M and W write r2 → 10.
- Branch: branchTakenE=1 together with load-use condition → flushD=flushE=1, stalls 0.
- OUT with outAck after 3 cycles → 1 detect cycle, outValid high 3 cycles, pipeline resumes, outError=0.
- OUT_TIMEOUT=4, outAck never → release after 4 OUT_WAIT cycles, outError=1 and stays 1 over subsequent OUTs until reset.
- Reset asserted in OUT_WAIT → outValid, stalls, outError 0 immediately; first instruction after release decodes cleanly.
